fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch sequencer that drives the `program_counter` register from the other side. It issues word-addressed reads at the current `pc`, latches the returned word into the instruction register, and presents it to the decoder. It also computes `next_pc` every cycle: hold, increment, or branch redirect. `program_counter` loads `next_pc` on every rising edge, so this block must drive `next_pc = pc` whenever the PC is to hold.

## Interface
Parameters:
- `ADDR_W`, 16, PC / memory address width
- `DATA_W`, 16, instruction word width
- `PC_INC`, 1, word increment applied after each fetch

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  ADDR_W  current PC from `program_counter`
- `next_pc`  out  ADDR_W  value `program_counter` loads at the next edge (combinational)
- `pc_write`  out  1  high in any cycle where `next_pc != pc` is intended (advance or redirect)
- `mem_req`  out  1  read request to instruction memory
- `mem_addr`  out  ADDR_W  read address; equals `pc` whenever `mem_req` = 1
- `mem_ready`  in  1  read data valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `ir`  out  DATA_W  instruction register
- `ir_valid`  out  1  `ir` holds an unconsumed instruction
- `ir_ack`  in  1  decoder has finished with `ir` this cycle
- `redirect`  in  1  taken branch/jump; sampled only together with `ir_ack`
- `redirect_pc`  in  ADDR_W  branch target

## Operation
States: `S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD`.

Reset values:
- state `S_IDLE`
- `ir` = 0, `ir_valid` = 0, `mem_req` = 0, `pc_write` = 0
- `next_pc` = `pc`

Transitions:
- `S_IDLE`: outputs idle; always moves to `S_REQ` next cycle.
- `S_REQ` / `S_WAIT`: `mem_req` = 1, `mem_addr` = `pc`.
  - If `mem_ready`: `ir` <= `mem_rdata`, `ir_valid` <= 1, `next_pc` = `pc + PC_INC`, `pc_write` = 1; move to `S_HOLD`.
  - Otherwise: `next_pc` = `pc`; move to or stay in `S_WAIT`.
- `S_HOLD`: `mem_req` = 0, `ir` stable, `ir_valid` = 1.
  - No `ir_ack`: hold, with `next_pc` = `pc`.
  - `ir_ack` without `redirect`: `ir_valid` <= 0, `next_pc` = `pc`; move to `S_REQ` (fetches the already-incremented PC).
  - `ir_ack` with `redirect`: `ir_valid` <= 0, `next_pc` = `redirect_pc`, `pc_write` = 1; move to `S_REQ`.

Arithmetic: `pc + PC_INC` is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no flag.

## Timing
- `next_pc` and `pc_write` are combinational from state, `pc`, `mem_ready`, `ir_ack` and `redirect`. `ir` and `ir_valid` are registered.
- Fetch latency: `ir_valid` rises 1 cycle after the `mem_ready` cycle. With zero wait states, `ir_ack` to the next `ir_valid` takes 2 cycles.
- `mem_req` stays high and `mem_addr` stays stable from entry into `S_REQ` until the `mem_ready` cycle inclusive.
- Ignored inputs:
  - `mem_ready` outside `S_REQ`/`S_WAIT`
  - `ir_ack` outside `S_HOLD`
  - `redirect` without `ir_ack`
- Reset mid-fetch (`S_WAIT`): `mem_req` is 0 from the cycle after the reset edge. The abandoned read's `mem_ready` is ignored. `ir_valid` clears.
- `reset` wins over every simultaneous event, including `mem_ready` and `ir_ack`.
- Redirect to the current `pc`: still asserts `pc_write` and re-fetches that address.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum `fetch_state_t`
  - constants `ADDR_W`, `DATA_W`, `PC_INC`, `RESET_IR` = 0
- Optional sub-module `next_pc_mux`: the hold/increment/redirect select. The FSM and IR latch stay in this module.
- The bench instantiates this block together with `program_counter`, closing the `pc`/`next_pc` loop.

## Test plan
- Reset, then a zero-wait memory returning 0x1234 at address 0 -> `ir` = 0x1234 with `ir_valid` 1 cycle after `mem_ready`, and `pc` = 0x0001.
- Memory with 3 wait cycles -> `mem_req` high for 4 cycles with `mem_addr` = 0x0001 throughout; `pc` stays 0x0001 until the ready cycle, then becomes 0x0002.
- In `S_HOLD` with `pc` = 0x0005, `ir_ack` + `redirect` with `redirect_pc` = 0x0010 -> `pc` = 0x0010, and the next `mem_addr` is 0x0010.
- `redirect` high without `ir_ack` for 5 cycles -> `pc`, `ir` and `ir_valid` unchanged.
- `pc` = 0xFFFF fetch completes -> `pc` = 0x0000, and the next fetch is at 0x0000.
- `reset` asserted during `S_WAIT` with `mem_ready` arriving that same cycle -> `ir` = 0, `ir_valid` = 0, `mem_req` = 0 next cycle, and the state restarts via `S_IDLE`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch path.
package fetch_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int PC_INC   = 1;
    localparam int RESET_IR = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_INC,
        NPC_REDIRECT
    } npc_sel_t;

endpackage

// File: rtl/next_pc_mux.sv
// Selects the value program_counter loads next: hold, increment or branch target.
module next_pc_mux
    import fetch_pkg::*;
#(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int PC_INC = fetch_pkg::PC_INC
) (
    input  npc_sel_t          sel_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // The increment wraps modulo 2^ADDR_W with no carry out.
    always_comb begin
        case (sel_i)
            NPC_INC:      next_pc_o = pc_i + ADDR_W'(PC_INC);
            NPC_REDIRECT: next_pc_o = redirect_pc_i;
            default:      next_pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// PC register: loads next_pc on every rising edge, clears to zero on reset.
module program_counter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads memory at pc, holds the word in ir for the
// decoder, and steers program_counter through next_pc.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W,
    parameter int PC_INC = fetch_pkg::PC_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_write,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    // state  | meaning
    // S_IDLE | just out of reset, no request outstanding
    // S_REQ  | first request cycle at pc
    // S_WAIT | request held while memory stalls
    // S_HOLD | ir valid, waiting for the decoder to ack

    fetch_state_t      state_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              mem_req_q;
    npc_sel_t          npc_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= DATA_W'(RESET_IR);
            ir_valid_q <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_REQ;
                    mem_req_q <= 1'b1;
                end
                S_REQ, S_WAIT: begin
                    if (mem_ready) begin
                        state_q    <= S_HOLD;
                        ir_q       <= mem_rdata;
                        ir_valid_q <= 1'b1;
                        mem_req_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (ir_ack) begin
                        state_q    <= S_REQ;
                        ir_valid_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    ir_valid_q <= 1'b0;
                    mem_req_q  <= 1'b0;
                end
            endcase
        end
    end

    // The PC already points past ir once in S_HOLD, so a plain ack holds it.
    always_comb begin
        npc_sel = NPC_HOLD;
        if (!reset) begin
            case (state_q)
                S_REQ, S_WAIT: if (mem_ready)            npc_sel = NPC_INC;
                S_HOLD:        if (ir_ack && redirect)   npc_sel = NPC_REDIRECT;
                default:       npc_sel = NPC_HOLD;
            endcase
        end
    end

    next_pc_mux #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_next_pc_mux (
        .sel_i         (npc_sel),
        .pc_i          (pc),
        .redirect_pc_i (redirect_pc),
        .next_pc_o     (next_pc)
    );

    assign pc_write = (npc_sel != NPC_HOLD);
    assign mem_req  = mem_req_q;
    assign mem_addr = pc;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Closed-loop bench: fetch_sequencer plus program_counter against a memory model and fetch scoreboard.
module tb_fetch_sequencer;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc, next_pc, mem_addr, redirect_pc;
    logic          pc_write, mem_req, mem_ready, ir_valid, ir_ack, redirect;
    logic [DW-1:0] mem_rdata, ir;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_ready_cyc = -10;
    int wait_cfg = 0;
    bit spur_en = 1'b0;
    logic [AW-1:0] last_fetch = '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PC_INC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .pc_write    (pc_write),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ack      (ir_ack),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    program_counter #(.ADDR_W(AW)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .next_pc (next_pc),
        .pc      (pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Memory contents: a fixed word at address 0, a scrambled address elsewhere.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == '0) return 16'h1234;
        h = 32'(a) * 32'd40503 + 32'h0000_5A5A;
        return h[DW-1:0] ^ h[31:16];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: wait_cfg stall cycles per request (negative = random 0..3).
    initial begin : responder
        int wl;
        bit busy;
        wl = 0;
        busy = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = DW'($urandom);
            if (reset || !mem_req) begin
                busy = 1'b0;
                if (spur_en && !reset) mem_ready = 1'($urandom_range(0, 1));
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wl = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
                end
                if (wl == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    last_ready_cyc = cyc;
                    busy = 1'b0;
                end else begin
                    wl--;
                end
            end
        end
    end

    // Scoreboard monitor: every rising ir_valid must match the oldest expected fetch.
    initial begin : monitor
        bit prev_v;
        logic [DW-1:0] held;
        logic [AW-1:0] pc_exp;
        exp_t e;
        prev_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (ir_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ir_valid: ir=%0h with no fetch expected", ir);
                end else begin
                    e = exp_q.pop_front();
                    pc_exp = e.addr + AW'(1);
                    chk("ir_data", ir, e.data);
                    chk("pc_after_fetch", pc, pc_exp);
                    chk("fetch_latency", cyc - last_ready_cyc, 1);
                    held = e.data;
                end
            end else if (ir_valid && prev_v) begin
                chk("ir_stable", ir, held);
            end
            prev_v = ir_valid;
        end
    end

    task automatic wait_valid(input logic [AW-1:0] addr, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ir_valid) return;
            if (mem_req) begin
                req_cycles++;
                chk("mem_addr", mem_addr, addr);
                if (!mem_ready) chk("pc_hold_wait", pc, addr);
            end
        end
        total++;
        bad++;
        $display("FAIL fetch_timeout: ir_valid never rose for addr %0h", addr);
    endtask

    // From S_HOLD: idle hold_cyc cycles (redirect noise without ack), then ack and fetch.
    task automatic fetch_next(input bit redir, input logic [AW-1:0] tgt, input int hold_cyc,
                              input bit hold_redir, output int req_cycles);
        logic [AW-1:0] pc_m, nxt;
        exp_t e;
        pc_m = last_fetch + AW'(1);
        for (int i = 0; i < hold_cyc; i++) begin
            @(posedge clk);
            #1;
            redirect = hold_redir | 1'($urandom_range(0, 1));
            redirect_pc = AW'($urandom);
            @(negedge clk);
            chk("hold_pc", pc, pc_m);
            chk("hold_pc_write", pc_write, 1'b0);
            chk("hold_ir_valid", ir_valid, 1'b1);
            chk("hold_ir", ir, mem_word(last_fetch));
        end
        nxt = redir ? tgt : pc_m;
        e.addr = nxt;
        e.data = mem_word(nxt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ir_ack = 1'b1;
        redirect = redir;
        redirect_pc = redir ? tgt : AW'($urandom);
        @(negedge clk);
        chk("ack_pc", pc, pc_m);
        chk("ack_next_pc", next_pc, nxt);
        chk("ack_pc_write", pc_write, redir);
        @(posedge clk);
        #1;
        ir_ack = 1'b0;
        redirect = 1'b0;
        last_fetch = nxt;
        wait_valid(nxt, req_cycles);
    endtask

    initial begin : stimulus
        int n;
        int k;
        exp_t e;
        reset = 1'b1;
        ir_ack = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ir", ir, 0);
        chk("reset_ir_valid", ir_valid, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_pc_write", pc_write, 0);
        chk("reset_next_pc", next_pc, 0);

        // First fetch, zero wait states.
        e.addr = '0;
        e.data = 16'h1234;
        exp_q.push_back(e);
        last_fetch = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_valid(16'h0000, n);
        chk("first_ir", ir, 16'h1234);
        chk("first_pc", pc, 16'h0001);

        // Three wait states at address 1.
        wait_cfg = 3;
        fetch_next(1'b0, '0, 0, 1'b0, n);
        chk("wait3_req_cycles", n, 4);
        chk("wait3_pc", pc, 16'h0002);

        // Walk to pc = 5, then redirect to 0x0010.
        wait_cfg = 0;
        for (int i = 0; i < 3; i++) fetch_next(1'b0, '0, 0, 1'b0, n);
        chk("pre_redirect_pc", pc, 16'h0005);
        fetch_next(1'b1, 16'h0010, 0, 1'b0, n);
        chk("redirect_pc", pc, 16'h0011);

        // Five cycles of redirect without ack, then wrap through 0xFFFF.
        fetch_next(1'b1, 16'hFFFF, 5, 1'b1, n);
        chk("wrap_pc", pc, 16'h0000);
        fetch_next(1'b0, '0, 0, 1'b0, n);
        chk("wrap_refetch_ir", ir, 16'h1234);

        // Random traffic with stalls, redirects and stray mem_ready.
        wait_cfg = -1;
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fetch_next($urandom_range(0, 3) == 0, AW'($urandom),
                       int'($urandom_range(0, 3)), 1'b0, n);
        end

        // Reset landing in S_WAIT on the same cycle mem_ready arrives.
        spur_en = 1'b0;
        wait_cfg = 3;
        @(posedge clk);
        #1;
        ir_ack = 1'b1;
        @(posedge clk);
        #1;
        ir_ack = 1'b0;
        #1;
        k = 0;
        while (!mem_ready && k < 10) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("reset_race_ready_seen", mem_ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_race_next_pc", next_pc, pc);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_race_ir", ir, 0);
        chk("reset_race_ir_valid", ir_valid, 0);
        chk("reset_race_mem_req", mem_req, 0);
        chk("reset_race_pc", pc, 0);
        wait_cfg = 0;
        e.addr = '0;
        e.data = 16'h1234;
        exp_q.push_back(e);
        last_fetch = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("restart_idle_mem_req", mem_req, 0);
        wait_valid(16'h0000, n);
        chk("restart_req_cycles", n, 1);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
